// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: one bit per cycle, 32 cycles per operation.
// Optional divider is built only when MDU_DIV_EN is defined; otherwise funct3 4-7 report illegal.
module mdu_iter (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] opA,
    input  logic [31:0] opB,
    input  logic [4:0]  rd,
    output logic        busy,
    output logic        done,
    output logic        wr,
    output logic [4:0]  waddr,
    output logic [31:0] wdata,
    output logic        illegal
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] mag_a_q, mag_a_d;
    logic [63:0] acc_q, acc_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        neg_q, neg_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        wr_q, wr_d;
    logic [4:0]  waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        illegal_q, illegal_d;

    logic        sgn_a, sgn_b, sa, sb;
    logic [31:0] abs_a, abs_b, res;
    logic [32:0] sum33;
    logic [63:0] mul_acc, prod;

`ifdef MDU_DIV_EN
    logic [31:0] mag_b_q, mag_b_d;
    logic        rneg_q, rneg_d;
    logic [32:0] r_sh, diff;
    logic [63:0] div_acc;
    logic [31:0] quo, rem;
`endif

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rd_d      = rd_q;
        mag_a_d   = mag_a_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        done_d    = 1'b0;
        wr_d      = 1'b0;
        waddr_d   = '0;
        wdata_d   = '0;
        illegal_d = 1'b0;
        res       = '0;

        sgn_a = (funct3 == 3'd1) || (funct3 == 3'd2) || (funct3 == 3'd4) || (funct3 == 3'd6);
        sgn_b = (funct3 == 3'd1) || (funct3 == 3'd4) || (funct3 == 3'd6);
        sa    = opA[31] & sgn_a;
        sb    = opB[31] & sgn_b;
        abs_a = sa ? -opA : opA;
        abs_b = sb ? -opB : opB;

        // Multiplier lives in acc[31:0] and shifts out LSB-first while the product grows in from the top.
        sum33   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mag_a_q} : 33'd0);
        mul_acc = {sum33, acc_q[31:1]};
        prod    = neg_q ? -mul_acc : mul_acc;

`ifdef MDU_DIV_EN
        mag_b_d = mag_b_q;
        rneg_d  = rneg_q;
        // Restoring step: partial remainder in acc[63:32], dividend shifts out of acc[31:0] as quotient shifts in.
        r_sh    = {acc_q[63:32], acc_q[31]};
        diff    = r_sh - {1'b0, mag_b_q};
        div_acc = diff[32] ? {r_sh[31:0], acc_q[30:0], 1'b0}
                           : {diff[31:0], acc_q[30:0], 1'b1};
        quo     = div_acc[31:0];
        rem     = div_acc[63:32];
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d  = funct3;
                    rd_d  = rd;
                    cnt_d = '0;
                    neg_d = sa ^ sb;
                    if (funct3[2]) begin
`ifdef MDU_DIV_EN
                        rneg_d  = sa;
                        mag_b_d = abs_b;
                        acc_d   = {32'd0, abs_a};
                        if (opB == 32'd0) begin
                            state_d = DONE;
                            res     = funct3[1] ? opA : 32'hFFFF_FFFF;
                        end else if (!funct3[0] && opA == 32'h8000_0000 && opB == 32'hFFFF_FFFF) begin
                            state_d = DONE;
                            res     = funct3[1] ? 32'd0 : 32'h8000_0000;
                        end else begin
                            state_d = CALC;
                        end
`else
                        state_d   = DONE;
                        illegal_d = 1'b1;
                        done_d    = 1'b1;
`endif
                    end else begin
                        mag_a_d = abs_a;
                        acc_d   = {32'd0, abs_b};
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                cnt_d = cnt_q + 6'd1;
`ifdef MDU_DIV_EN
                if (op_q[2]) begin
                    acc_d = div_acc;
                    res   = op_q[1] ? (rneg_q ? -rem : rem) : (neg_q ? -quo : quo);
                end else begin
                    acc_d = mul_acc;
                    res   = (op_q == 3'd0) ? prod[31:0] : prod[63:32];
                end
`else
                acc_d = mul_acc;
                res   = (op_q == 3'd0) ? prod[31:0] : prod[63:32];
`endif
                if (cnt_q == 6'd31) begin
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        if (state_d == DONE && !illegal_d) begin
            done_d  = 1'b1;
            wr_d    = (rd_d != 5'd0);
            waddr_d = rd_d;
            wdata_d = res;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            op_q      <= '0;
            rd_q      <= '0;
            mag_a_q   <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wr_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            illegal_q <= 1'b0;
`ifdef MDU_DIV_EN
            mag_b_q   <= '0;
            rneg_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
            mag_a_q   <= mag_a_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            wr_q      <= wr_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            illegal_q <= illegal_d;
`ifdef MDU_DIV_EN
            mag_b_q   <= mag_b_d;
            rneg_q    <= rneg_d;
`endif
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign wr      = wr_q;
    assign waddr   = waddr_q;
    assign wdata   = wdata_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed self-checking bench for mdu_iter; divide vectors apply when MDU_DIV_EN is defined.
module tb_mdu_iter;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] opA, opB;
    logic [4:0]  rd;
    logic        busy, done, wr, illegal;
    logic [4:0]  waddr;
    logic [31:0] wdata;

    int unsigned n_cmp;
    int unsigned n_err;

    mdu_iter dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .funct3  (funct3),
        .opA     (opA),
        .opB     (opB),
        .rd      (rd),
        .busy    (busy),
        .done    (done),
        .wr      (wr),
        .waddr   (waddr),
        .wdata   (wdata),
        .illegal (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one op, scramble inputs after acceptance, measure edges from acceptance to done.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] r, input int unsigned elat,
                          input logic [31:0] ew, input logic eill, input bit poke);
        int unsigned lat;
        @(negedge clk);
        funct3 = f3;
        opA    = a;
        opB    = b;
        rd     = r;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        funct3 = 3'($urandom_range(0, 7));
        opA    = $urandom;
        opB    = $urandom;
        rd     = 5'($urandom_range(0, 31));
        check({tag, ".busy"}, 64'(busy), 64'd1);
        lat = 0;
        while (!done && lat < 40) begin
            if (poke && lat == 5) begin
                funct3 = 3'd3;
                rd     = 5'd9;
                start  = 1'b1;
            end
            if (poke && lat == 6) start = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, ".lat"}, 64'(lat), 64'(elat));
        check({tag, ".wdata"}, 64'(wdata), 64'(ew));
        check({tag, ".wr"}, 64'(wr), 64'(!eill && r != 5'd0));
        check({tag, ".waddr"}, 64'(waddr), eill ? 64'd0 : 64'(r));
        check({tag, ".illegal"}, 64'(illegal), 64'(eill));
        @(posedge clk);
        #1;
        check({tag, ".after"}, {59'd0, busy, done, wr, illegal, |wdata}, 64'd0);
    endtask

    initial begin
        int unsigned ndone;
        n_cmp  = 0;
        n_err  = 0;
        reset  = 1'b0;
        start  = 1'b0;
        funct3 = '0;
        opA    = '0;
        opB    = '0;
        rd     = '0;
        #12;
        check("reset.outs", {busy, done, wr, illegal, waddr, wdata}, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        run_op("mul7x6",   3'd0, 32'd7,          32'd6,          5'd5,  32, 32'd42,         1'b0, 1'b0);
        run_op("mulh_m1",  3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd3,  32, 32'h0000_0000,  1'b0, 1'b0);
        run_op("mulhu_m1", 3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd4,  32, 32'hFFFF_FFFE,  1'b0, 1'b0);
        run_op("mulhsu",   3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd6,  32, 32'hFFFF_FFFF,  1'b0, 1'b0);
        run_op("mulh_min", 3'd1, 32'h8000_0000,  32'h8000_0000,  5'd7,  32, 32'h4000_0000,  1'b0, 1'b0);
        run_op("mulh_neg", 3'd1, 32'hFFFF_FFFD,  32'd5,          5'd8,  32, 32'hFFFF_FFFF,  1'b0, 1'b0);
        run_op("mul_neg",  3'd0, 32'hFFFF_FFFD,  32'd5,          5'd31, 32, 32'hFFFF_FFF1,  1'b0, 1'b0);
        run_op("mul_rd0",  3'd0, 32'd7,          32'd6,          5'd0,  32, 32'd42,         1'b0, 1'b0);
        run_op("mul_poke", 3'd0, 32'd7,          32'd6,          5'd5,  32, 32'd42,         1'b0, 1'b1);

`ifdef MDU_DIV_EN
        run_op("div_m7_2",  3'd4, 32'hFFFF_FFF9, 32'd2,          5'd10, 32, 32'hFFFF_FFFD,  1'b0, 1'b0);
        run_op("rem_m7_2",  3'd6, 32'hFFFF_FFF9, 32'd2,          5'd11, 32, 32'hFFFF_FFFF,  1'b0, 1'b0);
        run_op("div_7_m2",  3'd4, 32'd7,         32'hFFFF_FFFE,  5'd12, 32, 32'hFFFF_FFFD,  1'b0, 1'b0);
        run_op("rem_7_m2",  3'd6, 32'd7,         32'hFFFF_FFFE,  5'd13, 32, 32'd1,          1'b0, 1'b0);
        run_op("divu_100",  3'd5, 32'd100,       32'd7,          5'd14, 32, 32'd14,         1'b0, 1'b0);
        run_op("remu_100",  3'd7, 32'd100,       32'd7,          5'd15, 32, 32'd2,          1'b0, 1'b0);
        run_op("remu_big",  3'd7, 32'hFFFF_FFFF, 32'h8000_0000,  5'd16, 32, 32'h7FFF_FFFF,  1'b0, 1'b0);
        run_op("divu_z",    3'd5, 32'h0000_1234, 32'd0,          5'd17, 0,  32'hFFFF_FFFF,  1'b0, 1'b0);
        run_op("rem_z",     3'd6, 32'h0000_1234, 32'd0,          5'd18, 0,  32'h0000_1234,  1'b0, 1'b0);
        run_op("div_ovf",   3'd4, 32'h8000_0000, 32'hFFFF_FFFF,  5'd19, 0,  32'h8000_0000,  1'b0, 1'b0);
        run_op("rem_ovf",   3'd6, 32'h8000_0000, 32'hFFFF_FFFF,  5'd20, 0,  32'd0,          1'b0, 1'b0);
`else
        run_op("divu_ill",  3'd5, 32'h0000_1234, 32'd5,          5'd17, 0,  32'd0,          1'b1, 1'b0);
        run_op("rem_ill",   3'd6, 32'hFFFF_FFF9, 32'd2,          5'd18, 0,  32'd0,          1'b1, 1'b0);
`endif

        // Abort a multiply with an asynchronous reset ten edges in.
        @(negedge clk);
        funct3 = 3'd0;
        opA    = 32'd7;
        opB    = 32'd6;
        rd     = 5'd5;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b0;
        #2;
        check("abort.outs", {busy, done, wr, illegal, waddr, wdata}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        ndone = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done || wr || busy) ndone++;
        end
        check("abort.quiet", 64'(ndone), 64'd0);
        run_op("post_abort", 3'd0, 32'd7, 32'd6, 5'd5, 32, 32'd42, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mdu_iter.md
MDU_ITER -- requirements
Module: mdu_iter

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on posedge clk.
REQ-002 SHALL have port reset, input, 1, asynchronous active-low reset; asserting it low clears all state immediately.
REQ-003 SHALL have port start, input, 1, request to begin an operation; sampled only in IDLE.
REQ-004 SHALL have port funct3, input, 3, RV32M op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-005 SHALL have ports opA and opB, input, 32 each, rs1 and rs2 operands taken from register-file read ports A and B.
REQ-006 SHALL have port rd, input, 5, destination register index.
REQ-007 SHALL have port busy, output, 1, high while an operation is in flight; low only in IDLE.
REQ-008 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-009 SHALL have ports wr (1), waddr (5) and wdata (32), outputs, write-back request driven directly into register-file write port.
REQ-010 SHALL have port illegal, output, 1, one-cycle pulse for an op that is not supported.

Function
REQ-011 SHALL implement FSM states IDLE, CALC and DONE; reset state is IDLE.
REQ-012 IDLE with start=1 at edge N: SHALL latch funct3, rd and operands; SHALL take absolute values where the op is signed; SHALL record result sign; SHALL enter CALC.
REQ-013 CALC SHALL run exactly 32 iterations, one bit per cycle, using a 6-bit counter.
REQ-014 Multiply SHALL use shift-add over a 64-bit product.
REQ-015 Divide SHALL use restoring shift-subtract producing a 32-bit quotient and a 32-bit remainder.
REQ-016 After the 32nd iteration the FSM SHALL enter DONE; the DONE cycle SHALL be cycle N+33.
REQ-017 In DONE, done SHALL be 1 for exactly one cycle, and wdata SHALL carry the selected and sign-corrected result.
REQ-018 Result selection: MUL returns product[31:0]; MULH, MULHSU and MULHU return product[63:32]; DIV and DIVU return the quotient; REM and REMU return the remainder.
REQ-019 Sign rules: the quotient is negated if signs differ; the remainder takes the sign of the dividend; MULHSU treats opA as signed and opB as unsigned.
REQ-020 In DONE, wr SHALL equal (rd != 0) and waddr SHALL equal rd.
REQ-021 wr, waddr and wdata SHALL be 0 outside DONE.
REQ-022 rd=0 SHALL still pulse done, with wr=0.
REQ-023 Divide by zero SHALL skip CALC and enter DONE at N+1; quotient = 0xFFFFFFFF, remainder = opA.
REQ-024 Signed overflow (opA=0x80000000, opB=0xFFFFFFFF, DIV/REM) SHALL skip CALC and enter DONE at N+1; quotient = 0x80000000, remainder = 0.
REQ-025 start asserted while busy=1 SHALL be ignored, with no queuing; changes on operand inputs after acceptance SHALL NOT affect the result.
REQ-026 DONE SHALL return to IDLE unconditionally; a start in the cycle after DONE SHALL be accepted.

Reset
REQ-027 reset low SHALL force IDLE, clear the counter and datapath registers, and drive busy, done, wr, waddr, wdata and illegal to 0, regardless of clk.
REQ-028 Reset asserted mid-CALC SHALL abort the operation; no done and no wr SHALL be produced for it after reset release.

Configuration
REQ-029 Macro MDU_DIV_EN defined: all eight funct3 ops SHALL be supported as specified above.
REQ-030 MDU_DIV_EN undefined: divider logic SHALL be removed; funct3 4-7 SHALL go to DONE at N+1 with done=1, illegal=1, wr=0 and wdata=0; multiply behaviour SHALL be unchanged.
REQ-031 illegal SHALL be 0 at all other times.

Verification
REQ-032 MUL, opA=7, opB=6, rd=5, start at edge N -> busy from N+1; at N+33 done=1, wr=1, waddr=5, wdata=42.
REQ-033 MULH, opA=0xFFFFFFFF, opB=0xFFFFFFFF -> wdata=0x00000000; MULHU with the same operands -> 0xFFFFFFFE.
REQ-034 DIV, opA=-7, opB=2 -> wdata=0xFFFFFFFD; REM with the same operands -> wdata=0xFFFFFFFF.
REQ-035 DIVU, opB=0, opA=0x1234 -> done at N+1 with wdata=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> done at N+1 with wdata=0x80000000.
REQ-036 Start MUL, pulse reset low at N+10, then release -> all outputs 0 and busy=0; no done ever follows; a new start is then accepted normally.
REQ-037 Second start while busy -> ignored; MUL with rd=0 -> done=1 and wr=0; without MDU_DIV_EN, DIVU -> illegal=1 at N+1.
